// File: rtl/wb_preset_init_seq_if.sv
// Wishbone bus bundle: master drives cyc/stb/we/adr/sel/dat_w,
// slave returns dat_r/ack/err/stall.
interface wb_preset_init_seq_if #(
    parameter int ADDR_WIDTH = 8
);
    logic                  cyc;
    logic                  stb;
    logic                  we;
    logic [ADDR_WIDTH-1:0] adr;
    logic [3:0]            sel;
    logic [31:0]           dat_w;
    logic [31:0]           dat_r;
    logic                  ack;
    logic                  err;
    logic                  stall;

    modport master (
        output cyc, stb, we, adr, sel, dat_w,
        input  dat_r, ack, err, stall
    );

    modport slave (
        input  cyc, stb, we, adr, sel, dat_w,
        output dat_r, ack, err, stall
    );
endinterface

// File: rtl/wb_preset_init_seq.sv
// Wishbone owner in front of a register bank: writes a preset table
// after reset (or on start_i), then passes the host bus straight through.
// Ports: clk_i, rst_n_i (async active-low), start_i replay pulse,
//   tbl_adr_i/tbl_dat_i packed table, host_if (slave side from host),
//   bank_if (master side to bank), busy_o, done_o, error_o, err_idx_o.
module wb_preset_init_seq #(
    parameter  int N_ENTRIES  = 4,
    parameter  int ADDR_WIDTH = 8,
    parameter  int TIMEOUT    = 15,
    localparam int IW = (N_ENTRIES > 1) ? $clog2(N_ENTRIES) : 1,
    localparam int CW = $clog2(TIMEOUT + 1)
) (
    input  logic                            clk_i,
    input  logic                            rst_n_i,
    input  logic                            start_i,
    input  logic [N_ENTRIES*ADDR_WIDTH-1:0] tbl_adr_i,
    input  logic [N_ENTRIES*32-1:0]         tbl_dat_i,
    wb_preset_init_seq_if.slave             host_if,
    wb_preset_init_seq_if.master            bank_if,
    output logic                            busy_o,
    output logic                            done_o,
    output logic                            error_o,
    output logic [IW-1:0]                   err_idx_o
);

    typedef enum logic [1:0] {
        S_REQ,
        S_ACK,
        S_DONE,
        S_DRAIN
    } state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          error_q, error_d;
    logic [IW-1:0] eidx_q, eidx_d;
    logic          fail;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_REQ;
            idx_q   <= '0;
            cnt_q   <= '0;
            error_q <= 1'b0;
            eidx_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            error_q <= error_d;
            eidx_q  <= eidx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        error_d = error_q;
        eidx_d  = eidx_q;
        fail    = 1'b0;

        bank_if.cyc   = 1'b0;
        bank_if.stb   = 1'b0;
        bank_if.we    = 1'b0;
        bank_if.adr   = '0;
        bank_if.sel   = 4'h0;
        bank_if.dat_w = 32'h0;

        host_if.ack   = 1'b0;
        host_if.err   = 1'b0;
        host_if.dat_r = 32'h0;
        host_if.stall = host_if.cyc & host_if.stb;

        unique case (state_q)
            S_REQ: begin
                bank_if.cyc   = 1'b1;
                bank_if.stb   = 1'b1;
                bank_if.we    = 1'b1;
                bank_if.sel   = 4'hF;
                bank_if.adr   = tbl_adr_i[int'(idx_q)*ADDR_WIDTH +: ADDR_WIDTH];
                bank_if.dat_w = tbl_dat_i[int'(idx_q)*32 +: 32];
                if (!bank_if.stall) state_d = S_ACK;
            end
            S_ACK: begin
                bank_if.cyc = 1'b1;
                cnt_d = cnt_q + CW'(1);
                // err takes priority over a simultaneous ack
                fail = bank_if.err | (cnt_q == CW'(TIMEOUT - 1));
                if (fail || bank_if.ack) begin
                    cnt_d = '0;
                    if (fail) begin
                        error_d = 1'b1;
                        eidx_d  = idx_q;
                    end
                    if (idx_q == IW'(N_ENTRIES - 1)) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + IW'(1);
                        state_d = S_REQ;
                    end
                end
            end
            S_DONE: begin
                bank_if.cyc   = host_if.cyc;
                bank_if.stb   = host_if.stb;
                bank_if.we    = host_if.we;
                bank_if.adr   = host_if.adr;
                bank_if.sel   = host_if.sel;
                bank_if.dat_w = host_if.dat_w;
                host_if.ack   = bank_if.ack;
                host_if.err   = bank_if.err;
                host_if.dat_r = bank_if.dat_r;
                host_if.stall = bank_if.stall;
                if (start_i) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                // let the open host cycle finish, but admit no new strobe
                bank_if.cyc   = host_if.cyc;
                bank_if.we    = host_if.we;
                bank_if.adr   = host_if.adr;
                bank_if.sel   = host_if.sel;
                bank_if.dat_w = host_if.dat_w;
                host_if.ack   = bank_if.ack;
                host_if.err   = bank_if.err;
                host_if.dat_r = bank_if.dat_r;
                if (!host_if.cyc) begin
                    error_d = 1'b0;
                    eidx_d  = '0;
                    idx_d   = '0;
                    cnt_d   = '0;
                    state_d = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase

        // the bus is released for as long as reset is held
        if (!rst_n_i) begin
            bank_if.cyc   = 1'b0;
            bank_if.stb   = 1'b0;
            bank_if.we    = 1'b0;
            bank_if.adr   = '0;
            bank_if.sel   = 4'h0;
            bank_if.dat_w = 32'h0;
        end
    end

    assign busy_o    = (state_q != S_DONE);
    assign done_o    = (state_q == S_DONE);
    assign error_o   = error_q;
    assign err_idx_o = eidx_q;

endmodule

// File: tb/tb_wb_preset_init_seq.sv
// Bench for wb_preset_init_seq: bank model, host driver, and a
// scoreboard monitor for bank writes and host read data.
module tb_wb_preset_init_seq;
    localparam int N  = 4;
    localparam int AW = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic [N*AW-1:0] tbl_adr;
    logic [N*32-1:0] tbl_dat;
    logic busy, done, error;
    logic [1:0] err_idx;

    wb_preset_init_seq_if #(.ADDR_WIDTH(AW)) h_if ();
    wb_preset_init_seq_if #(.ADDR_WIDTH(AW)) m_if ();

    wb_preset_init_seq #(
        .N_ENTRIES(N), .ADDR_WIDTH(AW), .TIMEOUT(15)
    ) dut (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start),
        .tbl_adr_i(tbl_adr), .tbl_dat_i(tbl_dat),
        .host_if(h_if), .bank_if(m_if),
        .busy_o(busy), .done_o(done),
        .error_o(error), .err_idx_o(err_idx)
    );

    always #5 clk = ~clk;

    int cyc_no = 0;
    always @(posedge clk) cyc_no <= cyc_no + 1;

    int total = 0;
    int bad = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // bank model
    logic [31:0] regs [0:63];
    bit stall_en = 0, err_en = 0, noack_en = 0;
    logic [AW-1:0] stall_adr = '0, err_adr = '0, noack_adr = '0;
    int stall_cnt;

    assign m_if.stall = stall_en && m_if.cyc && m_if.stb &&
                        (m_if.adr == stall_adr) && (stall_cnt < 3);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_if.ack   <= 1'b0;
            m_if.err   <= 1'b0;
            m_if.dat_r <= 32'h0;
            stall_cnt  <= 0;
        end else begin
            m_if.ack <= 1'b0;
            m_if.err <= 1'b0;
            if (m_if.cyc && m_if.stb) begin
                if (m_if.stall) begin
                    stall_cnt <= stall_cnt + 1;
                end else if (err_en && m_if.adr == err_adr) begin
                    m_if.err <= 1'b1;
                end else if (noack_en && m_if.adr == noack_adr) begin
                    m_if.ack <= 1'b0;
                end else begin
                    m_if.ack <= 1'b1;
                    if (m_if.we) regs[m_if.adr[7:2]] <= m_if.dat_w;
                    else m_if.dat_r <= regs[m_if.adr[7:2]];
                end
            end
        end
    end

    // scoreboard
    typedef struct {
        logic [AW-1:0] a;
        logic [31:0]   d;
    } wr_t;
    wr_t wq[$];
    logic [31:0] rq[$];
    int nwr = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (m_if.cyc && m_if.stb && m_if.we) begin
                if (wq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_write: got adr %h want none",
                             m_if.adr);
                end else begin
                    chk("wr_adr", 32'(m_if.adr), 32'(wq[0].a));
                    chk("wr_dat", m_if.dat_w, wq[0].d);
                    chk("wr_sel", 32'(m_if.sel), 32'hF);
                    if (!m_if.stall) begin
                        void'(wq.pop_front());
                        nwr++;
                    end
                end
            end
            if (h_if.ack) begin
                if (rq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL spurious_host_ack: got ack want none");
                end else begin
                    chk("host_rdata", h_if.dat_r, rq.pop_front());
                end
            end
        end
    end

    task automatic push_table();
        nwr = 0;
        for (int k = 0; k < N; k++)
            wq.push_back('{tbl_adr[k*AW +: AW], tbl_dat[k*32 +: 32]});
    endtask

    task automatic release_rst(output int t0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        t0 = cyc_no;
    endtask

    task automatic wait_done(input string nm, input int t0,
                             input int exp_cyc);
        bit seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(posedge clk);
            #1 seen = done;
        end
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL %s_done_timeout: got done=0 want 1", nm);
        end else begin
            chk({nm, "_latency"}, cyc_no - t0, exp_cyc);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    int t0;
    logic [N*32-1:0] dat_a, dat_b;

    initial begin
        h_if.cyc = 0; h_if.stb = 0; h_if.we = 0;
        h_if.adr = '0; h_if.sel = 4'hF; h_if.dat_w = '0;
        tbl_adr = {8'h0C, 8'h08, 8'h04, 8'h00};
        dat_a = {32'h44440003, 32'h33330002, 32'h22220001, 32'h11110000};
        dat_b = {32'hCAFE0003, 32'hCAFE0002, 32'hCAFE0001, 32'hCAFE0000};
        tbl_dat = dat_a;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 1);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_err_idx", err_idx, 0);
        chk("rst_m_cyc", m_if.cyc, 0);

        // 1: clean sequence
        push_table();
        release_rst(t0);
        wait_done("t1", t0, 8);
        chk("t1_busy", busy, 0);
        chk("t1_error", error, 0);
        chk("t1_nwr", nwr, 4);

        // 2: stall entry 1 for 3 cycles
        do_reset();
        stall_en = 1; stall_adr = 8'h04;
        push_table();
        release_rst(t0);
        wait_done("t2", t0, 11);
        chk("t2_nwr", nwr, 4);
        for (int k = 0; k < N; k++)
            chk("t2_reg", regs[k], tbl_dat[k*32 +: 32]);
        stall_en = 0;

        // 3: err on entry 2
        do_reset();
        tbl_dat = dat_b;
        err_en = 1; err_adr = 8'h08;
        push_table();
        release_rst(t0);
        wait_done("t3", t0, 8);
        chk("t3_error", error, 1);
        chk("t3_err_idx", err_idx, 2);
        chk("t3_reg3", regs[3], 32'hCAFE0003);
        chk("t3_reg2_kept", regs[2], 32'h33330002);
        err_en = 0;

        // 6a: start with host cycle open, replay clears error
        @(posedge clk);
        #1;
        h_if.cyc = 1; h_if.stb = 1; h_if.we = 0; h_if.adr = 8'h0C;
        start = 1;
        rq.push_back(32'hCAFE0003);
        @(posedge clk);
        #1 start = 0; h_if.stb = 0;
        chk("t6_drain_busy", busy, 1);
        chk("t6_drain_done", done, 0);
        @(posedge clk);
        #1 h_if.stb = 1;
        @(negedge clk);
        chk("t6_drain_stall", h_if.stall, 1);
        chk("t6_drain_mstb", m_if.stb, 0);
        chk("t6_drain_rq", rq.size(), 0);
        @(posedge clk);
        #1 h_if.stb = 0; h_if.cyc = 0;
        push_table();
        t0 = cyc_no;
        wait_done("t6a", t0, 9);
        chk("t6_error_clr", error, 0);
        chk("t6_err_idx_clr", err_idx, 0);
        chk("t6_nwr", nwr, 4);

        // 4 + 5: entry 0 never acked; host stalled meanwhile
        do_reset();
        tbl_dat = dat_a;
        noack_en = 1; noack_adr = 8'h00;
        push_table();
        release_rst(t0);
        @(posedge clk);
        #1 h_if.cyc = 1; h_if.stb = 1; h_if.we = 0; h_if.adr = 8'h04;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t5_seq_stall", h_if.stall, 1);
            chk("t5_seq_noack", h_if.ack, 0);
        end
        @(posedge clk);
        #1 h_if.cyc = 0; h_if.stb = 0;
        wait_done("t4", t0, 22);
        chk("t4_error", error, 1);
        chk("t4_err_idx", err_idx, 0);
        chk("t4_nwr", nwr, 4);
        noack_en = 0;

        // 5: host read after done, one-cycle latency
        @(posedge clk);
        #1 h_if.cyc = 1; h_if.stb = 1; h_if.adr = 8'h04;
        rq.push_back(32'h22220001);
        @(negedge clk);
        chk("t5_no_stall", h_if.stall, 0);
        @(posedge clk);
        #1 h_if.stb = 0;
        @(negedge clk);
        chk("t5_ack_latency", h_if.ack, 1);
        @(posedge clk);
        #1 h_if.cyc = 0;
        chk("t5_rq_empty", rq.size(), 0);

        // 6b: reset during entry 2 write of a replay
        @(posedge clk);
        #1 start = 1;
        push_table();
        @(posedge clk);
        #1 start = 0;
        begin
            bit hit = 0;
            for (int i = 0; i < 50 && !hit; i++) begin
                @(posedge clk);
                #1 hit = m_if.stb && (m_if.adr == 8'h08);
            end
            if (!hit) begin
                total++;
                bad++;
                $display("FAIL t6b_wait_entry2: got none want stb");
            end
        end
        #1 rst_n = 0;
        #1;
        chk("t6b_rst_cyc", m_if.cyc, 0);
        chk("t6b_rst_stb", m_if.stb, 0);
        chk("t6b_rst_busy", busy, 1);
        chk("t6b_pending", wq.size(), 2);
        wq.delete();
        repeat (2) @(posedge clk);
        push_table();
        release_rst(t0);
        wait_done("t6b", t0, 8);
        chk("t6b_nwr", nwr, 4);
        chk("t6b_error", error, 0);

        chk("end_wq_empty", wq.size(), 0);
        chk("end_rq_empty", rq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1);
    end
endmodule
